pc_seq_ctrl: RTL
================

// Module: pc_seq_ctrl
// PURPOSE
//  Next-PC sequencer for the ariscv fetch stage. Selects the value loaded into the PC register each cycle.
//  Sources: sequential +4, branch, jump, trap vector or return-from-trap.
//  Holds the PC on stall and buffers one pending redirect that arrives while stalled.
//  Saves the trapping PC in epc. Sits between the execute/CSR logic and the PC register.
// PARAMETERS
//  ADDR_W   32            PC/target width
//  RSTVAL   32'h0000_8000 boot PC, driven on pc_next while in BOOT
//  TRAP_VEC 32'h0000_8100 trap handler entry address
//  INC      4             sequential increment
// PORTS
//  clk         in  1      clock, rising edge
//  srst        in  1      synchronous reset, active-high
//  pc          in  ADDR_W current PC register value
//  stall       in  1      pipeline stall; PC must hold
//  br_valid    in  1      taken branch request
//  br_target   in  ADDR_W branch target
//  jmp_valid   in  1      jump request
//  jmp_target  in  ADDR_W jump target
//  trap_req    in  1      exception/trap request
//  ret_req     in  1      return-from-trap request
//  pc_next     out ADDR_W next PC; comb from state/inputs, PC register loads it every posedge
//  fetch_valid out 1      fetch at pc is valid this cycle
//  flush       out 1      kill younger instructions; 1-cycle pulse per redirect
//  epc         out ADDR_W PC captured at trap acceptance
//  misalign    out 1      1-cycle pulse, misaligned target (PC_ALIGN_CHECK_EN only)
// BEHAVIOUR
//  - Reset (srst=1 at posedge) → state=BOOT, pend_v=0, epc=RSTVAL.
//    While in BOOT: pc_next=RSTVAL, fetch_valid=0, flush=0, misalign=0.
//  - srst mid-operation discards any pending redirect and any in-progress TRAP.
//  - States: BOOT, RUN, HOLD (stalled with pending redirect), TRAP (1-cycle bubble).
//  - BOOT → RUN unconditionally after one cycle. BOOT ignores every request.
//  - Priority: trap_req > ret_req > jmp_valid > br_valid > sequential.
//  - RUN, stall=0, no request: pc_next = pc+INC, modulo 2^ADDR_W (FFFF_FFFC wraps to 0000_0000); fetch_valid=1.
//  - RUN, stall=0, redirect (ret/jmp/br): pc_next = target (ret uses epc); flush=1 in the same cycle.
//    New PC is visible one cycle after the request.
//  - stall=1 without trap: pc_next=pc, fetch_valid=0.
//    A redirect arriving while stalled is captured into the pending buffer and state → HOLD.
//  - HOLD: a later request overwrites the buffer only if its priority is higher; equal or lower priority is dropped.
//  - HOLD, stall falls: pc_next = pend target, flush=1, pend_v cleared, → RUN.
//    Any new request in that same cycle is ignored.
//  - trap_req in RUN or HOLD, whether stalled or not:
//    epc <= pc, pc_next = TRAP_VEC, flush=1, pend_v cleared, → TRAP.
//  - TRAP: fetch_valid=0, pc_next=pc, all requests ignored; → RUN next cycle.
//  - ret_req with trap_req in the same cycle: trap wins, ret is dropped.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined:
//    A redirect target with target[1:0]!=0 is not taken.
//    Instead: misalign=1, epc <= pc, pc_next=TRAP_VEC, flush=1, → TRAP (same path as trap_req).
//  PC_ALIGN_CHECK_EN undefined:
//    target[1:0] forced to 2'b00 on every redirect; misalign tied 0.
// STRUCTURE
//  - Shared header ariscv_defs.vh holds:
//    - state encodings ST_BOOT/ST_RUN/ST_HOLD/ST_TRAP (2 bits)
//    - redirect-source codes SRC_SEQ/SRC_BR/SRC_JMP/SRC_RET/SRC_TRAP and their priority order
//    - default RSTVAL/TRAP_VEC
//  - One sub-module: pc_redir_hold. It is the one-entry pending-redirect buffer.
//    Fields: valid, source code, target. Contains the priority-compare overwrite rule. FSM, mux and epc live in the top.
// TESTING
//  1. srst=1 for 3 cycles, then release:
//     pc_next=0000_8000, fetch_valid=0 for 1 cycle, then pc steps 8000, 8004, 8008.
//  2. pc=8010, br_valid=1, br_target=8040, stall=0:
//     flush=1 for 1 cycle, next pc=8040, then 8044.
//  3. stall=1 at pc=8020, br (target 8080), then jmp (target 80C0), then br (target 8100), one per cycle; stall drops:
//     pc holds 8020, then loads 80C0 with one flush pulse.
//  4. pc=8030, trap_req=1 with jmp_valid=1:
//     epc=8030, pc=8100, TRAP bubble (fetch_valid=0).
//     Later ret_req=1 → pc=8030, flush=1.
//  5. pc=FFFF_FFFC, no requests: next pc=0000_0000.
//     srst during HOLD with pending 9000: pc=8000, the pending 9000 is never taken.
//  6. jmp_target=8042:
//     with PC_ALIGN_CHECK_EN → misalign=1, pc=8100, epc=old pc.
//     without PC_ALIGN_CHECK_EN → pc=8040.

Source files
------------

// File: rtl/pc_seq_ctrl_pkg.sv
// Shared state/source encodings and default addresses for the ariscv next-PC sequencer.
package pc_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_TRAP = 2'd3
  } state_t;

  // Source codes are numbered in ascending priority, so ranking is a plain magnitude compare.
  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_JMP  = 3'd2,
    SRC_RET  = 3'd3,
    SRC_TRAP = 3'd4
  } src_t;

  localparam logic [31:0] DEF_RSTVAL   = 32'h0000_8000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_8100;
  localparam int          DEF_INC      = 4;

  function automatic logic src_outranks(input src_t a, input src_t b);
    return a > b;
  endfunction

endpackage

// File: rtl/pc_redir_hold.sv
// One-entry pending-redirect buffer; a new request replaces the entry only if it strictly outranks it.
module pc_redir_hold
  import pc_seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              clr,
  input  logic              load,
  input  src_t              req_src,
  input  logic [ADDR_W-1:0] req_target,
  output logic              pend_v,
  output logic [ADDR_W-1:0] pend_target
);

  src_t pend_src;
  logic take;

  always_comb begin
    take = load && (req_src != SRC_SEQ) && (!pend_v || src_outranks(req_src, pend_src));
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      pend_v      <= 1'b0;
      pend_src    <= SRC_SEQ;
      pend_target <= '0;
    end else if (clr) begin
      pend_v   <= 1'b0;
      pend_src <= SRC_SEQ;
    end else if (take) begin
      pend_v      <= 1'b1;
      pend_src    <= req_src;
      pend_target <= req_target;
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer for the ariscv fetch stage: sequential, branch, jump, trap and return sources.
// Optional build macro PC_ALIGN_CHECK_EN turns misaligned redirect targets into a trap.
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RSTVAL   = ADDR_W'(DEF_RSTVAL),
  parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(DEF_TRAP_VEC),
  parameter int                INC      = DEF_INC
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              trap_req,
  input  logic              ret_req,
  output logic [ADDR_W-1:0] pc_next,
  output logic              fetch_valid,
  output logic              flush,
  output logic [ADDR_W-1:0] epc,
  output logic              misalign
);

  state_t            state, state_nxt;
  src_t              req_src;
  logic [ADDR_W-1:0] req_target;
  logic              pend_v;
  logic [ADDR_W-1:0] pend_target;
  logic              hold_load, hold_clr;
  logic              redir_go, trap_go;
  logic [ADDR_W-1:0] redir_tgt;

  always_comb begin
    req_src    = SRC_SEQ;
    req_target = '0;
    if (ret_req) begin
      req_src    = SRC_RET;
      req_target = epc;
    end else if (jmp_valid) begin
      req_src    = SRC_JMP;
      req_target = jmp_target;
    end else if (br_valid) begin
      req_src    = SRC_BR;
      req_target = br_target;
    end
  end

  pc_redir_hold #(.ADDR_W(ADDR_W)) u_hold (
    .clk         (clk),
    .srst        (srst),
    .clr         (hold_clr),
    .load        (hold_load),
    .req_src     (req_src),
    .req_target  (req_target),
    .pend_v      (pend_v),
    .pend_target (pend_target)
  );

  // A pending redirect always wins when the stall lifts; fresh requests that cycle are dropped.
  always_comb begin
    state_nxt   = state;
    pc_next     = pc;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    misalign    = 1'b0;
    hold_load   = 1'b0;
    hold_clr    = 1'b0;
    redir_go    = 1'b0;
    redir_tgt   = '0;
    trap_go     = 1'b0;
    case (state)
      ST_BOOT: begin
        pc_next   = RSTVAL;
        state_nxt = ST_RUN;
      end
      ST_RUN, ST_HOLD: begin
        fetch_valid = ~stall;
        if (trap_req) begin
          trap_go = 1'b1;
        end else if (stall) begin
          hold_load = (req_src != SRC_SEQ);
          if (req_src != SRC_SEQ) state_nxt = ST_HOLD;
        end else if (pend_v) begin
          redir_go  = 1'b1;
          redir_tgt = pend_target;
        end else if (req_src != SRC_SEQ) begin
          redir_go  = 1'b1;
          redir_tgt = req_target;
        end else begin
          pc_next = pc + ADDR_W'(INC);
        end
      end
      ST_TRAP: state_nxt = ST_RUN;
      default: state_nxt = ST_BOOT;
    endcase

    if (redir_go) begin
      flush     = 1'b1;
      hold_clr  = 1'b1;
      state_nxt = ST_RUN;
`ifdef PC_ALIGN_CHECK_EN
      if (redir_tgt[1:0] != 2'b00) begin
        misalign = 1'b1;
        trap_go  = 1'b1;
      end else begin
        pc_next = redir_tgt;
      end
`else
      pc_next = redir_tgt & ~ADDR_W'(3);
`endif
    end

    if (trap_go) begin
      pc_next   = TRAP_VEC;
      flush     = 1'b1;
      hold_clr  = 1'b1;
      state_nxt = ST_TRAP;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state <= ST_BOOT;
      epc   <= RSTVAL;
    end else begin
      state <= state_nxt;
      if (trap_go) epc <= pc;
    end
  end

endmodule
